data_mem_responder: RTL and testbench

- Responder end of the data-cache request/response interface; sits between the execute/memory stages and the AXI master bridge.
- Accepts one load or store request per transaction (`req`/`addr_ok`) and issues a single-beat AXI read or write.
- Returns `data_ok` with the raw 32-bit word to the memory stage; the memory stage does byte/half extraction, with `data_ok` held until `resp_ready`.
- Supports flush: a cancelled transaction completes on the bus, but its response is suppressed.

---
 rtl/mem_if_pkg.sv | 25 ++
 rtl/data_mem_responder_if.sv | 75 +++++++
 rtl/data_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Definitions shared by the data- and instruction-side memory responders:
// FSM state encoding, access-size codes, default AXI ID and AXI size mapping.
package mem_if_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW   = 3'd3,
    B    = 3'd4,
    RESP = 3'd5
  } mem_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;

  // AXI encodes bytes-per-beat as log2, which is exactly the request size code.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Bundle of the data-cache request/response handshake and the single-beat AXI
// channels seen by data_mem_responder (slave) and its environment (master).
interface data_mem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // Request / response side
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              resp_ready;
  logic              cancel;

  // AXI read channels
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata_axi;
  logic              rvalid;
  logic              rready;

  // AXI write channels
  logic [3:0]        awid;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata_axi;
  logic [3:0]        wstrb_axi;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  req, wr, size, addr, wstrb, wdata, resp_ready, cancel,
    output addr_ok, data_ok, rdata,
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rdata_axi, rvalid,
    output rready,
    output awid, awaddr, awsize, awvalid,
    input  awready,
    output wdata_axi, wstrb_axi, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport master (
    output req, wr, size, addr, wstrb, wdata, resp_ready, cancel,
    input  addr_ok, data_ok, rdata,
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rdata_axi, rvalid,
    input  rready,
    input  awid, awaddr, awsize, awvalid,
    output awready,
    input  wdata_axi, wstrb_axi, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/data_mem_responder.sv
// Data-cache responder: one load/store at a time turned into a single-beat AXI
// transaction. Define DATA_EARLY_WACK_EN to acknowledge stores before bvalid.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  AXI_ID = AXI_ID_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  data_mem_responder_if.slave bus
);

`ifdef DATA_EARLY_WACK_EN
  localparam bit EARLY_WACK = 1'b1;
`else
  localparam bit EARLY_WACK = 1'b0;
`endif

  mem_state_e        state_q, state_d;

  logic              drop_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic              acked_q;

  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic accept;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic aw_fin, w_fin;
  logic drop_now;
  logic cancel_able;
  logic resp_cancel;
  logic early_pending;

  assign accept   = (state_q == IDLE) && bus.req && !bus.cancel;

  assign ar_hs    = bus.arvalid && bus.arready;
  assign r_hs     = bus.rready  && bus.rvalid;
  assign aw_hs    = bus.awvalid && bus.awready;
  assign w_hs     = bus.wvalid  && bus.wready;
  assign b_hs     = bus.bready  && bus.bvalid;

  assign aw_fin   = aw_done_q || aw_hs;
  assign w_fin    = w_done_q  || w_hs;

  // A flush arriving in the completion cycle suppresses that response too.
  assign drop_now = drop_q || bus.cancel;

  // With early store acks, B only drains bvalid; the response is already owed.
  assign cancel_able = (state_q == AR) || (state_q == R) || (state_q == AW) ||
                       ((state_q == B) && !EARLY_WACK);

  assign early_pending = EARLY_WACK && (state_q == B) && !drop_q && !acked_q;

  // Once an early store ack is pending or given, a flush can no longer revoke it.
  assign resp_cancel = bus.cancel && !(EARLY_WACK && wr_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its peers, matching real register behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = bus.wr ? AW : AR;
      AR:   if (ar_hs)  state_d = R;
      R:    if (r_hs)   state_d = drop_now ? IDLE : RESP;
      AW:   if (aw_fin && w_fin) state_d = B;
      B: begin
        if (b_hs) begin
          if (EARLY_WACK) begin
            state_d = (early_pending && !bus.resp_ready) ? RESP : IDLE;
          end else begin
            state_d = drop_now ? IDLE : RESP;
          end
        end
      end
      RESP: if (bus.resp_ready || resp_cancel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore: depends on state and per-transaction flags only)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.addr_ok = 1'b0;
    bus.data_ok = 1'b0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    case (state_q)
      IDLE: bus.addr_ok = 1'b1;
      AR:   bus.arvalid = 1'b1;
      R:    bus.rready  = 1'b1;
      AW: begin
        bus.awvalid = !aw_done_q;
        bus.wvalid  = !w_done_q;
      end
      B: begin
        bus.bready  = 1'b1;
        bus.data_ok = early_pending;
      end
      RESP: bus.data_ok = 1'b1;
      default: ;
    endcase
  end

  assign bus.rdata     = rdata_q;

  assign bus.arid      = AXI_ID;
  assign bus.araddr    = addr_q;
  assign bus.arsize    = axi_size(size_q);

  assign bus.awid      = AXI_ID;
  assign bus.awaddr    = addr_q;
  assign bus.awsize    = axi_size(size_q);
  assign bus.wdata_axi = wdata_q;
  assign bus.wstrb_axi = wstrb_q;
  assign bus.wlast     = 1'b1;

  // ---------------------------------------------------------------------------
  // Request latch, channel-completion flags, drop flag and load data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      drop_q    <= 1'b0;
      acked_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q      <= bus.wr;
        size_q    <= bus.size;
        addr_q    <= bus.addr;
        wstrb_q   <= bus.wstrb;
        wdata_q   <= bus.wdata;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        acked_q   <= 1'b0;
        // Stores report a zero word.
        if (bus.wr) rdata_q <= '0;
      end

      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (r_hs)  rdata_q   <= bus.rdata_axi;

      if ((state_q == B) && bus.data_ok && bus.resp_ready) acked_q <= 1'b1;

      if (state_d == IDLE) begin
        drop_q <= 1'b0;
      end else if (bus.cancel && cancel_able) begin
        drop_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_data_mem_responder;
  import mem_if_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_mem_responder #(
    .ADDR_W(32),
    .DATA_W(32),
    .AXI_ID(4'd1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t got=0x%08h exp=0x%08h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction described by what has
  // happened to it so far on each bus channel.
  bit          p_busy, p_wr, p_drop, p_ar, p_aw, p_w, p_done;
  logic [31:0] p_addr, p_wdata, p_word;
  logic [1:0]  p_size;
  logic [3:0]  p_wstrb;

  // Slave model: per-channel delays (cycles a valid waits for its ready, or
  // cycles before a response is offered) and the word a load will return.
  int          ar_dly, aw_dly, w_dly, r_dly, b_dly;
  int          ar_wait, aw_wait, w_wait, r_wait, b_wait;
  logic [31:0] r_word;
  bit          rand_dly;
  bit          saw_data_ok;

  task automatic start_txn();
    p_busy  = 1'b1;
    p_wr    = bus.wr;
    p_addr  = bus.addr;
    p_size  = bus.size;
    p_wstrb = bus.wstrb;
    p_wdata = bus.wdata;
    p_drop  = 1'b0;
    p_ar    = 1'b0;
    p_aw    = 1'b0;
    p_w     = 1'b0;
    p_done  = 1'b0;
    ar_wait = 0; aw_wait = 0; w_wait = 0; r_wait = 0; b_wait = 0;
    if (rand_dly) begin
      ar_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 4);
      b_dly  = $urandom_range(0, 4);
      r_word = $urandom();
    end
  endtask

  task automatic check_outputs();
    bit e_ar, e_r, e_aw, e_w, e_b, e_dok;
    e_ar  = p_busy && !p_wr && !p_ar;
    e_r   = p_busy && !p_wr && p_ar && !p_done;
    e_aw  = p_busy && p_wr && !p_aw;
    e_w   = p_busy && p_wr && !p_w;
    e_b   = p_busy && p_wr && p_aw && p_w && !p_done;
    e_dok = p_busy && p_done;
    check("addr_ok", bus.addr_ok, !p_busy);
    check("data_ok", bus.data_ok, e_dok);
    check("arvalid", bus.arvalid, e_ar);
    check("rready",  bus.rready,  e_r);
    check("awvalid", bus.awvalid, e_aw);
    check("wvalid",  bus.wvalid,  e_w);
    check("bready",  bus.bready,  e_b);
    if (e_dok && !p_wr) check("rdata", bus.rdata, p_word);
    if (e_ar) begin
      check("araddr", bus.araddr, p_addr);
      check("arsize", bus.arsize, {1'b0, p_size});
      check("arid",   bus.arid,   4'd1);
    end
    if (e_aw) begin
      check("awaddr", bus.awaddr, p_addr);
      check("awsize", bus.awsize, {1'b0, p_size});
      check("awid",   bus.awid,   4'd1);
    end
    if (e_w) begin
      check("wdata_axi", bus.wdata_axi, p_wdata);
      check("wstrb_axi", bus.wstrb_axi, p_wstrb);
      check("wlast",     bus.wlast,     1'b1);
    end
  endtask

  // Called just after a falling edge with the CPU inputs for this cycle set:
  // drive the slave, advance the model across the rising edge, then check.
  task automatic cycle();
    bit e_ar, e_r, e_aw, e_w, e_b;
    e_ar = p_busy && !p_wr && !p_ar;
    e_r  = p_busy && !p_wr && p_ar && !p_done;
    e_aw = p_busy && p_wr && !p_aw;
    e_w  = p_busy && p_wr && !p_w;
    e_b  = p_busy && p_wr && p_aw && p_w && !p_done;

    bus.arready   = e_ar && (ar_wait >= ar_dly);
    bus.awready   = e_aw && (aw_wait >= aw_dly);
    bus.wready    = e_w  && (w_wait  >= w_dly);
    bus.rvalid    = e_r  && (r_wait  >= r_dly);
    bus.rdata_axi = bus.rvalid ? r_word : $urandom();
    bus.bvalid    = e_b  && (b_wait  >= b_dly);

    if (reset) begin
      p_busy = 1'b0;
      p_word = '0;
    end else if (!p_busy) begin
      if (bus.req && !bus.cancel) start_txn();
    end else if (!p_done) begin
      if (bus.cancel) p_drop = 1'b1;
      if (e_ar) begin if (bus.arready) p_ar = 1'b1; else ar_wait++; end
      if (e_aw) begin if (bus.awready) p_aw = 1'b1; else aw_wait++; end
      if (e_w)  begin if (bus.wready)  p_w  = 1'b1; else w_wait++;  end
      if (e_r)  begin
        if (bus.rvalid) begin p_word = r_word; p_done = 1'b1; end
        else r_wait++;
      end
      if (e_b) begin
        if (bus.bvalid) begin p_word = '0; p_done = 1'b1; end
        else b_wait++;
      end
      if (p_done && p_drop) p_busy = 1'b0;
    end else if (bus.resp_ready || bus.cancel) begin
      p_busy = 1'b0;
    end

    @(posedge clk);
    @(negedge clk);
    if (bus.data_ok) saw_data_ok = 1'b1;
    check_outputs();
  endtask

  task automatic do_req(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [3:0] wstrb, input logic [31:0] wdata);
    bus.req   = 1'b1;
    bus.wr    = wr;
    bus.size  = size;
    bus.addr  = addr;
    bus.wstrb = wstrb;
    bus.wdata = wdata;
    cycle();
    bus.req   = 1'b0;
  endtask

  task automatic wait_data_ok(input string tag, input int max, output int n);
    n = 0;
    while (!bus.data_ok && n < max) begin
      cycle();
      n++;
    end
    if (!bus.data_ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (p_busy && n < 100) begin
      cycle();
      n++;
    end
    if (p_busy) check({tag, "_drain_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = SZ_WORD; bus.addr = '0;
    bus.wstrb = '0; bus.wdata = '0; bus.resp_ready = 1'b1; bus.cancel = 1'b0;
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.rvalid = 1'b0; bus.bvalid = 1'b0; bus.rdata_axi = '0;
    ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0;
    r_word = '0; rand_dly = 1'b0; saw_data_ok = 1'b0;
    p_busy = 1'b0; p_word = '0;

    reset = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    check("rst_rdata",   bus.rdata,   32'd0);
    check("rst_addr_ok", bus.addr_ok, 1'b1);
    reset = 1'b0;

    // Load word, everything ready at once: data_ok three cycles after accept.
    r_word = 32'hDEADBEEF;
    do_req(1'b0, SZ_WORD, 32'h1FC0_0010, 4'h0, 32'h0);
    check("t1_araddr", bus.araddr, 32'h1FC0_0010);
    check("t1_arsize", bus.arsize, 3'd2);
    wait_data_ok("t1", 20, n);
    check("t1_latency", n, 2);
    check("t1_rdata", bus.rdata, 32'hDEADBEEF);
    drain("t1");
    check("t1_addr_ok", bus.addr_ok, 1'b1);

    // Store byte, awready 3 cycles late, wready immediate.
    aw_dly = 3;
    do_req(1'b1, SZ_BYTE, 32'h8000_0003, 4'b1000, 32'hAB00_0000);
    check("t2_awvalid0", bus.awvalid, 1'b1);
    check("t2_wvalid0",  bus.wvalid,  1'b1);
    check("t2_wstrb",    bus.wstrb_axi, 4'b1000);
    cycle();
    check("t2_wvalid1",  bus.wvalid,  1'b0);
    check("t2_awvalid1", bus.awvalid, 1'b1);
    check("t2_awaddr",   bus.awaddr,  32'h8000_0003);
    wait_data_ok("t2", 20, n);
    check("t2_latency", n, 4);
    drain("t2");
    aw_dly = 0;

    // Load with a late rvalid, flushed while in R: no response.
    r_dly = 5;
    saw_data_ok = 1'b0;
    do_req(1'b0, SZ_HALF, 32'h0000_1002, 4'h0, 32'h0);
    cycle();
    check("t3_rready", bus.rready, 1'b1);
    bus.cancel = 1'b1;
    cycle();
    bus.cancel = 1'b0;
    n = 0;
    while (!bus.addr_ok && n < 20) begin
      cycle();
      n++;
    end
    check("t3_addr_ok_lat", n, 5);
    check("t3_no_data_ok", saw_data_ok, 1'b0);
    r_dly = 0;

    // Response held off for 4 cycles while a second request waits.
    bus.resp_ready = 1'b0;
    r_word = 32'h1234_5678;
    do_req(1'b0, SZ_WORD, 32'h0000_2000, 4'h0, 32'h0);
    wait_data_ok("t4", 20, n);
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      check("t4_data_ok", bus.data_ok, 1'b1);
      check("t4_rdata",   bus.rdata,   32'h1234_5678);
      check("t4_addr_ok", bus.addr_ok, 1'b0);
      cycle();
    end
    bus.req = 1'b0;
    bus.resp_ready = 1'b1;
    cycle();
    check("t4_idle", bus.addr_ok, 1'b1);

    // Request and flush in the same idle cycle: nothing issued.
    bus.req = 1'b1; bus.wr = 1'b0; bus.cancel = 1'b1; bus.addr = 32'h0000_4000;
    cycle();
    bus.req = 1'b0; bus.cancel = 1'b0;
    check("t5_arvalid", bus.arvalid, 1'b0);
    check("t5_awvalid", bus.awvalid, 1'b0);
    check("t5_addr_ok", bus.addr_ok, 1'b1);
    r_word = 32'h0BAD_F00D;
    do_req(1'b0, SZ_WORD, 32'h0000_4004, 4'h0, 32'h0);
    check("t5_accept", bus.arvalid, 1'b1);
    drain("t5");

    // Reset while awvalid is stalled.
    aw_dly = 10;
    do_req(1'b1, SZ_WORD, 32'h0000_5000, 4'hF, 32'hCAFE_BABE);
    cycle();
    check("t6_awvalid", bus.awvalid, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6_addr_ok", bus.addr_ok, 1'b1);
    check("t6_awvalid_rst", bus.awvalid, 1'b0);
    check("t6_wvalid_rst",  bus.wvalid,  1'b0);
    cycle();
    aw_dly = 0;

    // Random traffic with random slave timing, flushes and back-pressure.
    rand_dly = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.req        = ($urandom_range(0, 99) < 60);
      bus.wr         = $urandom_range(0, 1);
      bus.size       = 2'($urandom_range(0, 2));
      bus.addr       = $urandom();
      bus.wstrb      = 4'($urandom_range(0, 15));
      bus.wdata      = $urandom();
      bus.cancel     = ($urandom_range(0, 99) < 6);
      bus.resp_ready = ($urandom_range(0, 99) < 70);
      cycle();
    end
    bus.req = 1'b0; bus.cancel = 1'b0; bus.resp_ready = 1'b1;
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
